gan_param_loader: RTL and testbench
===================================

// Module: gan_param_loader
// PURPOSE
//  Upstream stage of GAN_shared_hw. Receives the 77 signed 6-bit operands (x1..x4, then all
//  layer 1..8 weights/biases) as a serial valid/ready word stream into a shadow bank.
//  Commits a complete, well-framed set to an active bank that drives the GAN's flat operand
//  inputs, then sequences Start and flags result availability after a fixed run time.
// PARAMETERS
//  DATA_W      6    operand width, signed two's complement
//  N_PARAMS    77   words per frame: 4 inputs + 73 weights/biases
//  RUN_CYCLES  40   cycles Start is held before Result_Valid asserts
// PORTS
//  Clock         in   1                 single clock, rising edge
//  Reset         in   1                 asynchronous, active-high
//  In_Data       in   DATA_W            operand word
//  In_Valid      in   1                 word present
//  In_Last       in   1                 qualifies final word of frame
//  In_Ready      out  1                 loader can accept a word
//  Param_Bus     out  N_PARAMS*DATA_W   active bank; slot k at [DATA_W*k +: DATA_W]
//  Start         out  1                 to GAN_shared_hw Start
//  Result_Valid  out  1                 f1..f4 at GAN output are final
//  Result_Ack    in   1                 consumer has taken f1..f4
//  Frame_Err     out  1                 one-cycle pulse on framing error
// BEHAVIOUR
//  - Reset: state IDLE, word count 0, run counter 0, both banks 0, In_Ready=1, Start=0,
//    Result_Valid=0, Frame_Err=0. Reset mid-frame or mid-run discards everything.
//  - Slot order: x1..x4 (0..3), w_l1_11..w_l1_44 (4..19), b_l1_1..4 (20..23), then l2..l8 in
//    GAN port order; b_l8_4 = slot 76.
//  - Handshake: word accepted on an edge where In_Valid && In_Ready; written to shadow[count],
//    count++. In_Data/In_Last ignored without In_Valid. Gaps in In_Valid allowed.
//  - IDLE: In_Ready=1. First accepted word -> LOAD (a Last on it -> error).
//  - LOAD: In_Ready=1.
//    Accept with count==N_PARAMS-1 && In_Last: same edge copies shadow (incl. this word) to
//    active, -> RUN.
//    Accept with In_Last && count<N_PARAMS-1, or count==N_PARAMS-1 && !In_Last:
//    Frame_Err=1 for the next cycle, count=0, -> IDLE, active bank unchanged.
//  - RUN: In_Ready=0, Start=1, run counter counts RUN_CYCLES-1 down to 0, then -> DONE.
//  - DONE: In_Ready=0, Start=1, Result_Valid=1.
//    Result_Ack -> IDLE next edge (Start=0, Result_Valid=0, count=0).
//    Ack outside DONE is ignored.
//  - Latency: Start rises the cycle after the final-word handshake, with Param_Bus already
//    updated. Result_Valid rises RUN_CYCLES cycles after Start.
//  - Active bank changes only on a good commit; Param_Bus is stable throughout RUN/DONE.
//  - No arithmetic on data; words stored bit-exact (sign preserved).
//  - Counter widths: ceil(log2(N_PARAMS)) for count, ceil(log2(RUN_CYCLES)) for run.
// STRUCTURE
//  - gan_pkg: DATA_W, N_PARAMS, SLOT_* localparams (SLOT_X1=0 ... SLOT_B_L8_4=76),
//    state encoding IDLE/LOAD/RUN/DONE.
//  - Sub-module gan_param_bank: shadow and active register arrays, write port (index, data,
//    we), commit strobe, flat Param_Bus output.
//  - Top: FSM, word and run counters, framing check.
// TESTING
//  - Good frame: 77 words x=0,1,1,0, w_l1_11=6 ... b_l8_4=-10, Last on word 77
//    -> Param_Bus slot1=6'h01, slot4=6'h06, slot76=6'h36; Start=1 the next cycle;
//    Result_Valid=1 exactly 40 cycles later.
//  - Early Last on word 10 -> Frame_Err pulse 1 cycle; Param_Bus stays all-zero; In_Ready=1;
//    Start=0.
//  - 77th word without Last -> Frame_Err; state IDLE; the following good frame loads
//    normally.
//  - Reset asserted at word 40 and again at run cycle 20 -> all outputs at reset values
//    immediately (async); Param_Bus=0.
//  - In_Valid toggling 1/0 every cycle over a full frame -> same Param_Bus as the dense
//    frame; Start timing relative to final handshake unchanged.
//  - Two frames with Result_Ack in between; second frame changes slot0 to -1
//    -> slot0=6'h3F only after the second commit; words presented in RUN/DONE are
//    not accepted.

Source files
------------

// File: rtl/gan_param_loader_pkg.sv
// Shared widths, slot indices and state encoding for the GAN parameter loader.
package gan_param_loader_pkg;

    localparam int unsigned DATA_W     = 6;
    localparam int unsigned N_PARAMS   = 77;
    localparam int unsigned RUN_CYCLES = 40;

    localparam int unsigned CNT_W = $clog2(N_PARAMS);
    localparam int unsigned RUN_W = $clog2(RUN_CYCLES);
    localparam int unsigned BUS_W = N_PARAMS * DATA_W;

    // Operand slot map; layers 2..8 follow b_l1_4 in GAN port order.
    localparam int unsigned SLOT_X1      = 0;
    localparam int unsigned SLOT_X2      = 1;
    localparam int unsigned SLOT_X3      = 2;
    localparam int unsigned SLOT_X4      = 3;
    localparam int unsigned SLOT_W_L1_11 = 4;
    localparam int unsigned SLOT_W_L1_44 = 19;
    localparam int unsigned SLOT_B_L1_1  = 20;
    localparam int unsigned SLOT_B_L1_4  = 23;
    localparam int unsigned SLOT_B_L8_4  = 76;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PARAMS - 1);
    localparam logic [RUN_W-1:0] RUN_INIT = RUN_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/gan_param_loader_bank.sv
// Shadow/active operand banks: words land in shadow, a commit copies the set to active.
module gan_param_loader_bank
    import gan_param_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [CNT_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_commit,
    output logic [BUS_W-1:0]  o_param_bus
);

    logic [DATA_W-1:0] r_shadow [N_PARAMS];
    logic [DATA_W-1:0] r_active [N_PARAMS];

    // Shadow bank write port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_PARAMS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_PARAMS; k++) begin
                if (i_we && (i_idx == CNT_W'(k))) begin
                    r_shadow[k] <= i_data;
                end
            end
        end
    end

    // Active bank commit; the word written on the commit edge bypasses shadow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_PARAMS; k++) begin
                r_active[k] <= '0;
            end
        end else if (i_commit) begin
            for (int k = 0; k < N_PARAMS; k++) begin
                r_active[k] <= (i_we && (i_idx == CNT_W'(k))) ? i_data : r_shadow[k];
            end
        end
    end

    // Flatten active bank onto the GAN operand bus
    always_comb begin
        o_param_bus = '0;
        for (int k = 0; k < N_PARAMS; k++) begin
            o_param_bus[k*DATA_W +: DATA_W] = r_active[k];
        end
    end

endmodule

// File: rtl/gan_param_loader.sv
// Serial operand loader for GAN_shared_hw: framing check, bank commit, Start/Result sequencing.
module gan_param_loader
    import gan_param_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic [BUS_W-1:0]  o_param_bus,
    output logic              o_start,
    output logic              o_result_valid,
    input  logic              i_result_ack,
    output logic              o_frame_err
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [RUN_W-1:0] r_run;
    logic             r_in_ready;
    logic             r_start;
    logic             r_result_valid;
    logic             r_frame_err;

    logic w_accept;
    logic w_commit;

    assign w_accept = i_in_valid && r_in_ready;
    assign w_commit = w_accept && (r_state == ST_LOAD) && (r_count == LAST_IDX) && i_in_last;

    gan_param_loader_bank u_bank (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (w_accept),
        .i_idx       (r_count),
        .i_data      (i_in_data),
        .i_commit    (w_commit),
        .o_param_bus (o_param_bus)
    );

    // Control FSM with word counter, run counter and registered handshake/status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_run          <= '0;
            r_in_ready     <= 1'b1;
            r_start        <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_in_last) begin
                            r_frame_err <= 1'b1;
                            r_count     <= '0;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_count == LAST_IDX) begin
                            r_count <= '0;
                            if (i_in_last) begin
                                r_state    <= ST_RUN;
                                r_in_ready <= 1'b0;
                                r_start    <= 1'b1;
                                r_run      <= RUN_INIT;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end else if (i_in_last) begin
                            r_frame_err <= 1'b1;
                            r_count     <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (r_run == '0) begin
                        r_state        <= ST_DONE;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_run <= r_run - RUN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_result_ack) begin
                        r_state        <= ST_IDLE;
                        r_start        <= 1'b0;
                        r_result_valid <= 1'b0;
                        r_in_ready     <= 1'b1;
                        r_count        <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_start        = r_start;
    assign o_result_valid = r_result_valid;
    assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_gan_param_loader.sv
// Directed bench for gan_param_loader: framing, commit, run timing, reset and ack sequencing.
module tb_gan_param_loader;
    import gan_param_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] i_in_data;
    logic              i_in_valid;
    logic              i_in_last;
    logic              o_in_ready;
    logic [BUS_W-1:0]  o_param_bus;
    logic              o_start;
    logic              o_result_valid;
    logic              i_result_ack;
    logic              o_frame_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] frame_a [N_PARAMS];
    logic [DATA_W-1:0] frame_b [N_PARAMS];
    logic [BUS_W-1:0]  exp_a;
    logic [BUS_W-1:0]  exp_b;
    logic [BUS_W-1:0]  zero_bus;

    gan_param_loader dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_data      (i_in_data),
        .i_in_valid     (i_in_valid),
        .i_in_last      (i_in_last),
        .o_in_ready     (o_in_ready),
        .o_param_bus    (o_param_bus),
        .o_start        (o_start),
        .o_result_valid (o_result_valid),
        .i_result_ack   (i_result_ack),
        .o_frame_err    (o_frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_in_valid   = 1'b0;
        i_in_last    = 1'b0;
        i_in_data    = '0;
        i_result_ack = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present one word, hold until handshake edge, then idle the bus with junk on data/last
    task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input int gap);
        int w;
        w          = 0;
        i_in_data  = d;
        i_in_valid = 1'b1;
        i_in_last  = last;
        while (!o_in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!o_in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_ready_timeout: in_ready=%b want 1", o_in_ready);
        end
        tick();
        i_in_valid = 1'b0;
        i_in_last  = 1'b1;
        i_in_data  = 6'h2A;
        repeat (gap) tick();
        i_in_last = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int gap);
        for (int k = 0; k < N_PARAMS; k++) begin
            send_word((sel == 0) ? frame_a[k] : frame_b[k], (k == N_PARAMS - 1),
                      (k == N_PARAMS - 1) ? 0 : gap);
        end
    endtask

    task automatic init_frames();
        for (int k = 0; k < N_PARAMS; k++) begin
            frame_a[k] = DATA_W'(k * 5 + 3);
        end
        frame_a[0]  = 6'h00;
        frame_a[1]  = 6'h01;
        frame_a[2]  = 6'h01;
        frame_a[3]  = 6'h00;
        frame_a[4]  = 6'h06;
        frame_a[76] = 6'h36;
        for (int k = 0; k < N_PARAMS; k++) begin
            frame_b[k] = frame_a[k];
        end
        frame_b[0] = 6'h3F;
        exp_a      = '0;
        exp_b      = '0;
        zero_bus   = '0;
        for (int k = 0; k < N_PARAMS; k++) begin
            exp_a[k*DATA_W +: DATA_W] = frame_a[k];
            exp_b[k*DATA_W +: DATA_W] = frame_b[k];
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", o_in_ready); end
        n_cmp++; if (o_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", o_start); end
        n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b want 0", o_result_valid); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", o_frame_err); end
        n_cmp++; if (o_param_bus !== zero_bus) begin n_err++; $display("FAIL rst_bus: got %h want 0", o_param_bus); end
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame(0, 0);
        n_cmp++; if (o_start !== 1'b1) begin n_err++; $display("FAIL good_start: got %b want 1", o_start); end
        n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL good_ready: got %b want 0", o_in_ready); end
        n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL good_rv0: got %b want 0", o_result_valid); end
        n_cmp++; if (o_param_bus[1*DATA_W +: DATA_W] !== 6'h01) begin n_err++; $display("FAIL good_slot1: got %h want 01", o_param_bus[1*DATA_W +: DATA_W]); end
        n_cmp++; if (o_param_bus[4*DATA_W +: DATA_W] !== 6'h06) begin n_err++; $display("FAIL good_slot4: got %h want 06", o_param_bus[4*DATA_W +: DATA_W]); end
        n_cmp++; if (o_param_bus[76*DATA_W +: DATA_W] !== 6'h36) begin n_err++; $display("FAIL good_slot76: got %h want 36", o_param_bus[76*DATA_W +: DATA_W]); end
        n_cmp++; if (o_param_bus !== exp_a) begin n_err++; $display("FAIL good_bus: got %h want %h", o_param_bus, exp_a); end
        // words offered and a stray ack during RUN must both be ignored
        i_in_valid = 1'b1;
        i_in_data  = 6'h3F;
        i_in_last  = 1'b1;
        for (int i = 1; i < RUN_CYCLES; i++) begin
            i_result_ack = (i == 5);
            tick();
        end
        i_result_ack = 1'b0;
        n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL good_rv_early: got %b want 0 at cycle 39", o_result_valid); end
        n_cmp++; if (o_start !== 1'b1) begin n_err++; $display("FAIL good_start_hold: got %b want 1", o_start); end
        tick();
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        n_cmp++; if (o_result_valid !== 1'b1) begin n_err++; $display("FAIL good_rv40: got %b want 1 at cycle 40", o_result_valid); end
        n_cmp++; if (o_param_bus !== exp_a) begin n_err++; $display("FAIL good_bus_run: got %h want %h", o_param_bus, exp_a); end
        i_result_ack = 1'b1;
        tick();
        i_result_ack = 1'b0;
        n_cmp++; if (o_start !== 1'b0) begin n_err++; $display("FAIL ack_start: got %b want 0", o_start); end
        n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL ack_rv: got %b want 0", o_result_valid); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL ack_ready: got %b want 1", o_in_ready); end
    endtask

    task automatic test_early_last();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send_word(frame_a[k], (k == 9), 0);
        end
        n_cmp++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL early_err: got %b want 1", o_frame_err); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL early_ready: got %b want 1", o_in_ready); end
        n_cmp++; if (o_start !== 1'b0) begin n_err++; $display("FAIL early_start: got %b want 0", o_start); end
        n_cmp++; if (o_param_bus !== zero_bus) begin n_err++; $display("FAIL early_bus: got %h want 0", o_param_bus); end
        tick();
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL early_err_pulse: got %b want 0", o_frame_err); end
    endtask

    task automatic test_no_last();
        do_reset();
        for (int k = 0; k < N_PARAMS; k++) begin
            send_word(frame_a[k], 1'b0, 0);
        end
        n_cmp++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL nolast_err: got %b want 1", o_frame_err); end
        n_cmp++; if (o_start !== 1'b0) begin n_err++; $display("FAIL nolast_start: got %b want 0", o_start); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL nolast_ready: got %b want 1", o_in_ready); end
        n_cmp++; if (o_param_bus !== zero_bus) begin n_err++; $display("FAIL nolast_bus: got %h want 0", o_param_bus); end
        tick();
        send_frame(0, 0);
        n_cmp++; if (o_start !== 1'b1) begin n_err++; $display("FAIL nolast_reload_start: got %b want 1", o_start); end
        n_cmp++; if (o_param_bus !== exp_a) begin n_err++; $display("FAIL nolast_reload_bus: got %h want %h", o_param_bus, exp_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            send_word(frame_a[k], 1'b0, 0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL rstload_ready: got %b want 1", o_in_ready); end
        n_cmp++; if (o_param_bus !== zero_bus) begin n_err++; $display("FAIL rstload_bus: got %h want 0", o_param_bus); end
        tick();
        rst = 1'b0;
        tick();
        send_frame(0, 0);
        repeat (20) tick();
        n_cmp++; if (o_param_bus !== exp_a) begin n_err++; $display("FAIL rstrun_pre_bus: got %h want %h", o_param_bus, exp_a); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_start !== 1'b0) begin n_err++; $display("FAIL rstrun_start: got %b want 0", o_start); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL rstrun_ready: got %b want 1", o_in_ready); end
        n_cmp++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL rstrun_rv: got %b want 0", o_result_valid); end
        n_cmp++; if (o_param_bus !== zero_bus) begin n_err++; $display("FAIL rstrun_bus: got %h want 0", o_param_bus); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gapped();
        int cyc;
        do_reset();
        send_frame(0, 1);
        n_cmp++; if (o_start !== 1'b1) begin n_err++; $display("FAIL gap_start: got %b want 1", o_start); end
        n_cmp++; if (o_param_bus !== exp_a) begin n_err++; $display("FAIL gap_bus: got %h want %h", o_param_bus, exp_a); end
        cyc = 0;
        while (!o_result_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        n_cmp++; if (cyc !== int'(RUN_CYCLES)) begin n_err++; $display("FAIL gap_rv_latency: got %0d want %0d", cyc, RUN_CYCLES); end
        i_result_ack = 1'b1;
        tick();
        i_result_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        send_frame(0, 0);
        cyc = 0;
        while (!o_result_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        n_cmp++; if (o_result_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rv_timeout: got %b want 1", o_result_valid); end
        // words offered in DONE must not land
        i_in_valid = 1'b1;
        i_in_data  = 6'h3F;
        i_in_last  = 1'b1;
        repeat (3) tick();
        n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready: got %b want 0", o_in_ready); end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        i_result_ack = 1'b1;
        tick();
        i_result_ack = 1'b0;
        for (int k = 0; k < N_PARAMS; k++) begin
            send_word(frame_b[k], (k == N_PARAMS - 1), 0);
            if (k == 4) begin
                n_cmp++; if (o_param_bus[0 +: DATA_W] !== 6'h00) begin n_err++; $display("FAIL b2b_slot0_early: got %h want 00", o_param_bus[0 +: DATA_W]); end
            end
        end
        n_cmp++; if (o_param_bus[0 +: DATA_W] !== 6'h3F) begin n_err++; $display("FAIL b2b_slot0: got %h want 3f", o_param_bus[0 +: DATA_W]); end
        n_cmp++; if (o_param_bus !== exp_b) begin n_err++; $display("FAIL b2b_bus: got %h want %h", o_param_bus, exp_b); end
        n_cmp++; if (o_start !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b want 1", o_start); end
    endtask

    initial begin
        rst          = 1'b1;
        i_in_valid   = 1'b0;
        i_in_last    = 1'b0;
        i_in_data    = '0;
        i_result_ack = 1'b0;
        init_frames();
        test_reset();
        test_good_frame();
        test_early_last();
        test_no_last();
        test_reset_mid();
        test_gapped();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
